// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: the serial line into the receiver and the
// byte/strobe/status signals out to the downstream 8-bit datapath.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    // Line driver / byte consumer side
    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );

    // Receiver side
    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line.
// One byte holding register, one-cycle rx_valid / frame_err strobes.
// Bit timing comes from a free counter clocked by clk; every decision is
// taken on the synchronised line rx_s.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic [1:0]       sync_reg;
    logic             rx_s;

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [2:0]       idx_reg,    idx_next;
    logic [7:0]       shift_reg,  shift_next;
    logic [7:0]       data_reg,   data_next;
    logic             valid_reg,  valid_next;
    logic             ferr_reg,   ferr_next;

    assign rx_s = sync_reg[1];

    // Two-flop synchroniser; presets to the idle level so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], bus.rx};
        end
    end

    // State, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= 8'h00;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    // Next-state logic: baud counter wraps at CLKS_PER_BIT and restarts on every state change
    always_comb begin
        state_next = state_reg;
        cnt_next   = (cnt_reg == BIT_LAST) ? '0 : cnt_reg + 1'b1;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end

            // Re-check the line at mid start bit to reject short glitches
            ST_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next = ST_DATA;
                        idx_next   = 3'd0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            // Sample at mid bit; shifting right lands the first (LSB) bit in bit 0
            ST_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                        cnt_next   = '0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end

            // Leave at mid stop bit so a back-to-back start edge is still caught
            ST_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end

            // Hold off until the line returns high so a held-low line is not re-framed
            ST_BREAK: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.rx_data   = data_reg;
    assign bus.rx_valid  = valid_reg;
    assign bus.frame_err = ferr_reg;
    assign bus.busy      = (state_reg != ST_IDLE);

endmodule
